// File: rtl/mecobo_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mecobo_cmd_pkg
// Brief    : Shared command-word layout, dispatcher FSM encoding and constants.
// Revision : 1.0 - initial release
// ============================================================================
package mecobo_cmd_pkg;

    localparam int CMD_W    = 80;
    localparam int TS_MSB   = 79;
    localparam int TS_LSB   = 48;
    localparam int ADDR_MSB = 47;
    localparam int ADDR_LSB = 32;
    localparam int DATA_MSB = 31;
    localparam int DATA_LSB = 0;
    localparam int TS_W     = TS_MSB - TS_LSB + 1;
    localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
    localparam int DATA_W   = DATA_MSB - DATA_LSB + 1;

    // A zero timestamp means "issue as soon as it reaches the head".
    localparam logic [TS_W-1:0] TS_IMMEDIATE = 32'd0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_WAIT_VALID = 3'd2,
        ST_HOLD       = 3'd3,
        ST_ISSUE      = 3'd4
    } disp_state_t;

    function automatic logic [TS_W-1:0] cmd_ts(input logic [CMD_W-1:0] word);
        return word[TS_MSB:TS_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [CMD_W-1:0] word);
        return word[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [DATA_W-1:0] cmd_data(input logic [CMD_W-1:0] word);
        return word[DATA_MSB:DATA_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_due_compare.sv
`default_nettype none
// ============================================================================
// Module   : cmd_due_compare
// Brief    : Combinational due/late evaluation of a timestamp against now.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_due_compare
    import mecobo_cmd_pkg::*;
(
    input  logic [TS_W-1:0] ts,
    input  logic [TS_W-1:0] now,
    input  logic [TS_W-1:0] limit,
    output logic            due,
    output logic            late
);

    logic [TS_W-1:0] w_diff;
    logic            w_immediate;
    logic            w_past;

    // Modulo-2^32 difference: MSB clear means ts is at or behind now.
    assign w_diff      = now - ts;
    assign w_past      = ~w_diff[TS_W-1];
    assign w_immediate = (ts == TS_IMMEDIATE);

    assign due  = w_immediate | w_past;
    assign late = ~w_immediate & w_past & (w_diff > limit);

endmodule
`default_nettype wire

// File: rtl/timed_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : timed_cmd_dispatcher
// Brief    : Pops timestamped commands from the FIFO and issues each one as a
//            single command-bus write once the global clock reaches it.
//            Optional late-drop feature: define DISPATCH_LATE_DROP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module timed_cmd_dispatcher
    import mecobo_cmd_pkg::*;
#(
    parameter logic [31:0] LATE_LIMIT = 32'd1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TS_W-1:0]   current_time,
    input  logic [CMD_W-1:0]  cmd_fifo_dout,
    input  logic              cmd_fifo_empty,
    input  logic              cmd_fifo_valid,
    output logic              cmd_fifo_rd_en,
    output logic [ADDR_W-1:0] cmd_bus_addr,
    output logic [DATA_W-1:0] cmd_bus_data,
    output logic              cmd_bus_en,
    output logic              cmd_bus_wr,
    output logic              busy,
    output logic [15:0]       late_count
);

`ifdef DISPATCH_LATE_DROP_EN
    localparam bit c_drop_en = 1'b1;
`else
    localparam bit c_drop_en = 1'b0;
`endif

    disp_state_t       r_state;
    logic [TS_W-1:0]   r_ts;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_data_hold;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_data;
    logic              r_bus_en;
    logic              r_bus_wr;

    logic              w_due;
    logic              w_late;
    logic              w_drop;
    disp_state_t       w_after_cmd;

    cmd_due_compare u_due_compare (
        .ts    (r_ts),
        .now   (current_time),
        .limit (LATE_LIMIT),
        .due   (w_due),
        .late  (w_late)
    );

    assign w_drop      = c_drop_en & w_late;
    assign w_after_cmd = cmd_fifo_empty ? ST_IDLE : ST_FETCH;

    // rd_en and the bus strobes are registered on the transition into
    // FETCH / ISSUE so they are high for exactly the cycle spent there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ts        <= '0;
            r_addr_hold <= '0;
            r_data_hold <= '0;
            r_rd_en     <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_data  <= '0;
            r_bus_en    <= 1'b0;
            r_bus_wr    <= 1'b0;
        end else begin
            r_rd_en  <= 1'b0;
            r_bus_en <= 1'b0;
            r_bus_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!cmd_fifo_empty) begin
                        r_state <= ST_FETCH;
                        r_rd_en <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_WAIT_VALID;
                end
                ST_WAIT_VALID: begin
                    if (cmd_fifo_valid) begin
                        r_ts        <= cmd_ts(cmd_fifo_dout);
                        r_addr_hold <= cmd_addr(cmd_fifo_dout);
                        r_data_hold <= cmd_data(cmd_fifo_dout);
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_drop) begin
                        r_state <= w_after_cmd;
                        r_rd_en <= ~cmd_fifo_empty;
                    end else if (w_due) begin
                        r_state    <= ST_ISSUE;
                        r_bus_en   <= 1'b1;
                        r_bus_wr   <= 1'b1;
                        r_bus_addr <= r_addr_hold;
                        r_bus_data <= r_data_hold;
                    end
                end
                ST_ISSUE: begin
                    r_state <= w_after_cmd;
                    r_rd_en <= ~cmd_fifo_empty;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        if (c_drop_en) begin : g_late_cnt
            logic [15:0] r_late_count;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_late_count <= '0;
                end else if ((r_state == ST_HOLD) && w_drop && (r_late_count != 16'hFFFF)) begin
                    r_late_count <= r_late_count + 16'd1;
                end
            end
            assign late_count = r_late_count;
        end else begin : g_no_late_cnt
            assign late_count = 16'd0;
        end
    endgenerate

    assign cmd_fifo_rd_en = r_rd_en;
    assign cmd_bus_addr   = r_bus_addr;
    assign cmd_bus_data   = r_bus_data;
    assign cmd_bus_en     = r_bus_en;
    assign cmd_bus_wr     = r_bus_wr;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_timed_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_timed_cmd_dispatcher
// Brief    : Directed table-driven bench for timed_cmd_dispatcher with a
//            behavioural FIFO (valid one cycle after rd_en).
// Revision : 1.0 - initial release
// ============================================================================
module tb_timed_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_time;
    logic [79:0] cmd_fifo_dout;
    logic        cmd_fifo_empty;
    logic        cmd_fifo_valid;
    logic        cmd_fifo_rd_en;
    logic [15:0] cmd_bus_addr;
    logic [31:0] cmd_bus_data;
    logic        cmd_bus_en;
    logic        cmd_bus_wr;
    logic        busy;
    logic [15:0] late_count;

    always #5 clk = ~clk;

    timed_cmd_dispatcher #(.LATE_LIMIT(32'd100)) dut (
        .clk            (clk),
        .rst            (rst),
        .current_time   (current_time),
        .cmd_fifo_dout  (cmd_fifo_dout),
        .cmd_fifo_empty (cmd_fifo_empty),
        .cmd_fifo_valid (cmd_fifo_valid),
        .cmd_fifo_rd_en (cmd_fifo_rd_en),
        .cmd_bus_addr   (cmd_bus_addr),
        .cmd_bus_data   (cmd_bus_data),
        .cmd_bus_en     (cmd_bus_en),
        .cmd_bus_wr     (cmd_bus_wr),
        .busy           (busy),
        .late_count     (late_count)
    );

    typedef struct {
        logic [31:0] ts;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] t0;
        bit          exp_issue;
        logic [31:0] exp_t;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          rd_violations = 0;
    bit          rd_seen = 1'b0;
    logic [79:0] fifo_q[$];
    logic [15:0] s_addr[$];
    logic [31:0] s_data[$];
    logic [31:0] s_time[$];
    logic        s_wr[$];
    int          s_cyc[$];
    int          rd_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: behavioural FIFO response, time advance and output capture.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        current_time   = current_time + 32'd1;
        cmd_fifo_valid = 1'b0;
        if (rd_seen && fifo_q.size() > 0) begin
            cmd_fifo_dout  = fifo_q.pop_front();
            cmd_fifo_valid = 1'b1;
        end
        cmd_fifo_empty = (fifo_q.size() == 0);
        rd_seen = cmd_fifo_rd_en && !rst;
        if (cmd_fifo_rd_en && cmd_fifo_empty) rd_violations++;
        if (cmd_fifo_rd_en) rd_cyc.push_back(cyc);
        if (cmd_bus_en) begin
            s_addr.push_back(cmd_bus_addr);
            s_data.push_back(cmd_bus_data);
            s_time.push_back(current_time);
            s_wr.push_back(cmd_bus_wr);
            s_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_logs();
        s_addr.delete(); s_data.delete(); s_time.delete();
        s_wr.delete(); s_cyc.delete(); rd_cyc.delete();
    endtask

    task automatic push_cmd(input logic [31:0] ts, input logic [15:0] a, input logic [31:0] d);
        fifo_q.push_back({ts, a, d});
        cmd_fifo_empty = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        // Expected strobe time = current_time during the cmd_bus_en cycle.
        // Word pushed with time t0: rd_en at t0+1, HOLD at t0+3, ISSUE at t0+4
        // when already due, otherwise the cycle after time reaches ts.
        vecs[0] = '{32'd0,          16'h0005, 32'hDEADBEEF, 32'd100,        1'b1, 32'd104};
        vecs[1] = '{32'd1000,       16'h0010, 32'h11111111, 32'd900,        1'b1, 32'd1001};
        vecs[2] = '{32'h00000010,   16'h0020, 32'h22222222, 32'hFFFFFFF0,   1'b1, 32'h00000011};
        vecs[3] = '{32'hFFFFFFF0,   16'h0021, 32'h33333333, 32'h00000010,   1'b1, 32'h00000014};
`ifdef DISPATCH_LATE_DROP_EN
        vecs[4] = '{32'd10,         16'h0030, 32'h44444444, 32'd500,        1'b0, 32'd0};
`else
        vecs[4] = '{32'd10,         16'h0030, 32'h44444444, 32'd500,        1'b1, 32'd504};
`endif
        vecs[5] = '{32'd450,        16'h0031, 32'h55555555, 32'd500,        1'b1, 32'd504};
        vecs[6] = '{32'd2003,       16'h0040, 32'h66666666, 32'd2000,       1'b1, 32'd2004};
        vecs[7] = '{32'd2005,       16'h0041, 32'h77777777, 32'd2000,       1'b1, 32'd2006};

        rst            = 1'b1;
        current_time   = 32'd0;
        cmd_fifo_dout  = '0;
        cmd_fifo_empty = 1'b1;
        cmd_fifo_valid = 1'b0;
        repeat (3) tick();
        chk("reset rd_en",  {63'd0, cmd_fifo_rd_en}, 64'd0);
        chk("reset en",     {63'd0, cmd_bus_en},     64'd0);
        chk("reset wr",     {63'd0, cmd_bus_wr},     64'd0);
        chk("reset addr",   {48'd0, cmd_bus_addr},   64'd0);
        chk("reset data",   {32'd0, cmd_bus_data},   64'd0);
        chk("reset busy",   {63'd0, busy},           64'd0);
        chk("reset late",   {48'd0, late_count},     64'd0);
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 8; i++) begin
            int  n;
            bit  seen_busy;
            clear_logs();
            push_cmd(vecs[i].ts, vecs[i].addr, vecs[i].data);
            current_time = vecs[i].t0;
            n = 0;
            seen_busy = 1'b0;
            while (!(seen_busy && !busy) && n < 300) begin
                tick();
                if (busy) seen_busy = 1'b1;
                n++;
            end
            chk($sformatf("vec%0d timeout", i), {63'd0, (n >= 300)}, 64'd0);
            chk($sformatf("vec%0d strobe count", i), 64'(s_addr.size()), 64'(vecs[i].exp_issue ? 1 : 0));
            if (vecs[i].exp_issue && s_addr.size() == 1) begin
                chk($sformatf("vec%0d addr", i), {48'd0, s_addr[0]}, {48'd0, vecs[i].addr});
                chk($sformatf("vec%0d data", i), {32'd0, s_data[0]}, {32'd0, vecs[i].data});
                chk($sformatf("vec%0d wr", i),   {63'd0, s_wr[0]},   64'd1);
                chk($sformatf("vec%0d time", i), {32'd0, s_time[0]}, {32'd0, vecs[i].exp_t});
                chk($sformatf("vec%0d addr hold", i), {48'd0, cmd_bus_addr}, {48'd0, vecs[i].addr});
                chk($sformatf("vec%0d en low after", i), {63'd0, cmd_bus_en}, 64'd0);
            end
            repeat (2) tick();
        end
`ifdef DISPATCH_LATE_DROP_EN
        chk("late_count", {48'd0, late_count}, 64'd1);
`else
        chk("late_count", {48'd0, late_count}, 64'd0);
`endif

        // Back-to-back: three due commands, strictly ordered, 4 clocks apart.
        begin
            int n;
            clear_logs();
            push_cmd(32'd0, 16'h0001, 32'hA0000001);
            push_cmd(32'd0, 16'h0002, 32'hA0000002);
            push_cmd(32'd0, 16'h0003, 32'hA0000003);
            current_time = 32'd7000;
            n = 0;
            while (s_addr.size() < 3 && n < 100) begin
                tick();
                n++;
            end
            chk("b2b strobe count", 64'(s_addr.size()), 64'd3);
            if (s_addr.size() == 3) begin
                chk("b2b order 0", {48'd0, s_addr[0]}, 64'd1);
                chk("b2b order 1", {48'd0, s_addr[1]}, 64'd2);
                chk("b2b order 2", {48'd0, s_addr[2]}, 64'd3);
                chk("b2b data 2",  {32'd0, s_data[2]}, 64'hA0000003);
                chk("b2b gap 01",  64'(s_cyc[1] - s_cyc[0]), 64'd4);
                chk("b2b gap 12",  64'(s_cyc[2] - s_cyc[1]), 64'd4);
                if (rd_cyc.size() > 0)
                    chk("rd_en to en latency", 64'(s_cyc[0] - rd_cyc[0]), 64'd3);
            end
            repeat (4) tick();
            chk("b2b busy done", {63'd0, busy}, 64'd0);
        end

        // Reset while holding a future command: it must never be issued.
        begin
            int n;
            clear_logs();
            push_cmd(32'd5000, 16'h0077, 32'hBADC0DE5);
            current_time = 32'd3990;
            n = 0;
            while (current_time != 32'd4000 && n < 50) begin
                tick();
                n++;
            end
            chk("hold busy before rst", {63'd0, busy}, 64'd1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("rst rd_en", {63'd0, cmd_fifo_rd_en}, 64'd0);
            chk("rst en",    {63'd0, cmd_bus_en},     64'd0);
            chk("rst wr",    {63'd0, cmd_bus_wr},     64'd0);
            chk("rst addr",  {48'd0, cmd_bus_addr},   64'd0);
            chk("rst data",  {32'd0, cmd_bus_data},   64'd0);
            chk("rst busy",  {63'd0, busy},           64'd0);
            chk("rst late",  {48'd0, late_count},     64'd0);
            n = 0;
            while (current_time != 32'd5100 && n < 2000) begin
                tick();
                n++;
            end
            chk("no strobe after rst", 64'(s_addr.size()), 64'd0);
            chk("idle after rst",      {63'd0, busy},      64'd0);
        end

        chk("rd_en while empty", 64'(rd_violations), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
